// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use detection, branch flush sequencing and
// ownership of the multi-cycle mult/div unit (start pulse plus busy tracking).
//
// state   | meaning
// RUN     | no mult/div result pending
// MD_BUSY | mult/div in flight; mfhi/mflo and new md ops must wait
module hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_store,
  input  logic             id_branch_taken,
  input  logic             id_md_op,
  input  logic             id_md_read,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MdCntW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  state_t            stateQ, stateD;
  logic [MdCntW-1:0] mdCntQ, mdCntD;
  logic              loadUse, mdHazard, stall, mdBusyRaw;

  // Store data on rt is forwarded in MEM, so a sw only stalls on its rs base.
  always_comb begin
    loadUse = ex_mem_read && (ex_rt != 5'd0) &&
              ((id_uses_rs && (ex_rt == id_rs)) ||
               (id_uses_rt && !id_is_store && (ex_rt == id_rt)));
    mdBusyRaw = (stateQ == MD_BUSY);
    mdHazard  = mdBusyRaw && (id_md_op || id_md_read);
    stall     = loadUse || mdHazard;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    md_start    = 1'b0;
    md_busy     = mdBusyRaw;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      md_busy     = 1'b0;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else begin
      md_start   = id_md_op;
      ifid_flush = id_branch_taken;
    end
  end

  always_comb begin
    stateD = stateQ;
    mdCntD = mdCntQ;
    if (md_start) begin
      stateD = MD_BUSY;
      mdCntD = MdCntW'(MD_LAT - 1);
    end else if (stateQ == MD_BUSY) begin
      if (mdCntQ == '0) begin
        stateD = RUN;
      end else begin
        mdCntD = mdCntQ - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ    <= RUN;
      mdCntQ    <= '0;
      stall_cnt <= '0;
    end else begin
      stateQ <= stateD;
      mdCntQ <= mdCntD;
      if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

  localparam int MdLat = 4;
  localparam int CntW  = 4;
  localparam int CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [4:0]      id_rs, id_rt, ex_rt;
  logic            id_uses_rs, id_uses_rt, id_is_store, id_branch_taken;
  logic            id_md_op, id_md_read, ex_mem_read;
  logic            pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_busy;
  logic [CntW-1:0] stall_cnt;

  int passCnt  = 0;
  int totalCnt = 0;

  // Reference model: remaining busy cycles and stall count as plain integers.
  int mdLeft   = 0;
  int expCnt   = 0;
  bit cntValid = 0;

  hazard_ctrl #(.MD_LAT(MdLat), .CNT_W(CntW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_store(id_is_store), .id_branch_taken(id_branch_taken),
    .id_md_op(id_md_op), .id_md_read(id_md_read),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .md_start(md_start), .md_busy(md_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic setIdle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_store = 1'b0;
    id_branch_taken = 1'b0; id_md_op = 1'b0; id_md_read = 1'b0;
    ex_mem_read = 1'b0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one cycle.
  task automatic step(input string tag);
    bit lu, busy, stl, expStart;
    logic [5:0] expFlags, obsFlags;
    lu = ex_mem_read && (ex_rt != 0) &&
         ((id_uses_rs && ex_rt == id_rs) ||
          (id_uses_rt && !id_is_store && ex_rt == id_rt));
    busy = (mdLeft > 0);
    stl  = lu || (busy && (id_md_op || id_md_read));
    expStart = rst_n && !stl && id_md_op;
    if (!rst_n)   expFlags = 6'b111100;
    else if (stl) expFlags = {4'b0001, 1'b0, busy};
    else          expFlags = {2'b11, id_branch_taken, 1'b0, expStart, busy};
    #1;
    obsFlags = {pc_write, ifid_write, ifid_flush, idex_bubble, md_start, md_busy};
    totalCnt++;
    assert (obsFlags === expFlags) passCnt++;
    else $error("FAIL %s flags{pc,ifid,flush,bubble,start,busy} got=%b exp=%b", tag, obsFlags, expFlags);
    if (cntValid) begin
      totalCnt++;
      assert (stall_cnt === CntW'(expCnt)) passCnt++;
      else $error("FAIL %s_cnt stall_cnt got=%0d exp=%0d", tag, stall_cnt, expCnt);
    end
    @(posedge clk);
    if (!rst_n) begin
      mdLeft = 0; expCnt = 0; cntValid = 1;
    end else begin
      if (stl && expCnt < CntMax) expCnt++;
      if (expStart)        mdLeft = MdLat;
      else if (mdLeft > 0) mdLeft--;
    end
    @(negedge clk);
  endtask

  task automatic expectCnt(input string tag, input int val);
    totalCnt++;
    assert (stall_cnt === CntW'(val)) passCnt++;
    else $error("FAIL %s stall_cnt got=%0d exp=%0d", tag, stall_cnt, val);
  endtask

  initial begin
    setIdle();
    rst_n = 1'b0;
    step("rst0");
    step("rst1");
    rst_n = 1'b1;

    // Load-use on rs: one stall cycle, then the load has moved on.
    ex_mem_read = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
    step("lu");
    expectCnt("lu_cnt", 1);
    ex_mem_read = 0;
    step("lu_rel");

    // sw with store-data dependency only, then with a base dependency too.
    ex_mem_read = 1; ex_rt = 5'd8; id_rt = 5'd8; id_uses_rt = 1; id_is_store = 1; id_rs = 5'd9;
    step("sw_exempt");
    id_rs = 5'd8;
    step("sw_base");
    expectCnt("sw_cnt", 2);

    setIdle();
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
    step("reg0");
    setIdle();
    id_branch_taken = 1;
    step("branch");
    ex_mem_read = 1; ex_rt = 5'd3; id_rt = 5'd3; id_uses_rt = 1;
    step("branch_lu");
    expectCnt("branch_cnt", 3);

    // mult then mflo: start pulse, four stalled cycles, release.
    setIdle();
    id_md_op = 1;
    step("md_start");
    id_md_op = 0; id_md_read = 1;
    for (int i = 0; i < MdLat; i++) step("md_read_stall");
    expectCnt("md_cnt", 7);
    step("md_read_rel");

    // Back-to-back mult with free-flowing adds in the shadow of the second one.
    setIdle();
    id_md_op = 1;
    step("md2_first");
    for (int i = 0; i < MdLat; i++) step("md2_wait");
    step("md2_second");
    id_md_op = 0; id_uses_rs = 1; id_uses_rt = 1; id_rs = 5'd4; id_rt = 5'd5;
    step("md2_add");
    step("md2_add2");

    // Reset lands mid-operation.
    setIdle();
    id_md_op = 1;
    step("mdrst_start");
    id_md_op = 0;
    step("mdrst_busy");
    rst_n = 0;
    step("mdrst_rst");
    rst_n = 1;
    id_md_read = 1;
    step("mdrst_read");
    expectCnt("mdrst_cnt", 0);
    step("mdrst_read2");

    // Hold a load-use long enough to saturate the counter.
    setIdle();
    ex_mem_read = 1; ex_rt = 5'd7; id_rs = 5'd7; id_uses_rs = 1;
    for (int i = 0; i < CntMax + 4; i++) step("sat");
    expectCnt("sat_cnt", CntMax);

    // Random traffic on a small register set so collisions are common.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] regs [3];
      regs[0] = 5'd0; regs[1] = 5'd8; regs[2] = 5'd9;
      rst_n           = ($urandom_range(0, 49) != 0);
      id_rs           = regs[$urandom_range(0, 2)];
      id_rt           = regs[$urandom_range(0, 2)];
      ex_rt           = regs[$urandom_range(0, 2)];
      id_uses_rs      = 1'($urandom);
      id_uses_rt      = 1'($urandom);
      id_is_store     = 1'($urandom);
      id_branch_taken = ($urandom_range(0, 3) == 0);
      id_md_op        = ($urandom_range(0, 5) == 0);
      id_md_read      = ($urandom_range(0, 3) == 0);
      ex_mem_read     = 1'($urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Sequences PC / IF-ID write enables, ID-EX bubble insertion and IF-ID flush.
- Detects load-use hazards. Exempts store-data dependencies, which the MEM-stage store-data forwarding path resolves.
- Owns the multi-cycle multiply/divide unit: issues its start pulse and stalls dependent instructions until the result is ready.

Parameters:
- MD_LAT, 4: multiply/divide latency in cycles (MD_LAT >= 2).
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- id_rs  in  5  ID-stage rs field.
- id_rt  in  5  ID-stage rt field.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt as an ALU/branch operand.
- id_is_store  in  1  ID instruction is sw; rt is store data only.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- id_md_op  in  1  ID instruction is mult/multu/div/divu.
- id_md_read  in  1  ID instruction is mfhi/mflo.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rt  in  5  EX load destination register.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register write enable.
- ifid_flush  out  1  zero the IF/ID register next edge.
- idex_bubble  out  1  load a NOP into ID/EX next edge.
- md_start  out  1  one-cycle start pulse to the mult/div unit.
- md_busy  out  1  mult/div result pending.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to RUN; md counter = 0; stall_cnt = 0.
  - While rst_n=0: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, md_start=0, md_busy=0.
  - Reset mid-multiply abandons the operation; no late start or stall follows.
- FSM states: RUN, MD_BUSY. md_busy = (state==MD_BUSY).
- Load-use hazard (lu), combinational. lu = ex_mem_read AND ex_rt!=0 AND at least one of:
  - ex_rt==id_rs with id_uses_rs;
  - ex_rt==id_rt with id_uses_rt and NOT id_is_store.
- A sw whose only dependency is store data on rt is NOT stalled.
- MD hazard (mdh) = md_busy AND (id_md_op OR id_md_read).
- stall = lu OR mdh.
- When stall=1:
  - pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
  - md_start=0.
  - id_branch_taken is ignored and re-evaluated when the stall releases.
- When stall=0 and id_branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0.
- Otherwise all enables = 1 and flush/bubble = 0.
- md_start = id_md_op AND NOT stall, in any state. A new op issues the cycle after the previous op's final busy cycle.
- MD timing:
  - On an md_start cycle: state goes to MD_BUSY and the counter loads MD_LAT-1.
  - In MD_BUSY the counter decrements each cycle. On the edge where the counter is 0, state returns to RUN.
  - md_busy is therefore high for exactly MD_LAT cycles after the start cycle.
  - Non-MD instructions flow freely during MD_BUSY.
- Simultaneous lu and mdh: a single stall cycle covers both. Stall persists while either holds.
- stall_cnt increments on every clock edge where stall=1 and saturates at all-ones. It is never cleared except by reset.
- A load-use stall lasts exactly one cycle, since the bubble moves the load to MEM and lu drops. This relies on the upstream ID/EX register honouring idex_bubble.
- Register $0 never causes a hazard.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5'd8, id_rs=8, id_uses_rs=1 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt 0->1; then all enables return to 1.
- Store-data exempt: ex_mem_read=1, ex_rt=8, id_rt=8, id_uses_rt=1, id_is_store=1, id_rs=9 -> no stall, idex_bubble=0. Same case with id_rs=8 -> stall.
- $0 and branch: ex_rt=0 matching id_rs=0 -> no stall. id_branch_taken=1 with no hazard -> ifid_flush=1, pc_write=1 for one cycle. Branch plus lu -> ifid_flush=0, stall only.
- Mult/div, MD_LAT=4: id_md_op pulse -> md_start=1 for one cycle, then md_busy high 4 cycles. id_md_read asserted in the next cycle -> stalled 4 cycles, stall_cnt +4, released as md_busy falls.
- Back-to-back mult: second id_md_op while busy -> stalled until busy ends, then md_start; an add during busy -> no stall.
- Reset mid-op: rst_n=0 during MD_BUSY -> md_busy=0, stall_cnt=0, outputs at reset values. After release, id_md_read=1 -> no stall.
